// File: rtl/projectile_engine.sv
// projectile_engine: per-frame projectile physics feeding the VGA painter.
// Launches a shot on a fire-button press, integrates position under gravity
// once per frame, and detects ground landing and edge-box exits.
//
// Ports:
//   clk          system clock (same as display counters)
//   reset        asynchronous active-low reset
//   button       debounced fire request, synchronous to clk
//   vel_x        unsigned horizontal launch speed, px/frame
//   vel_y        unsigned upward launch speed, px/frame
//   hCount       horizontal pixel count (not used by the physics)
//   vCount       vertical line count, source of the frame strobe
//   projX/projY  projectile position in hCount/vCount space
//   proj_active  high while the projectile is in flight
//   hit_ground   one-cycle pulse on landing
//   hit_wall     one-cycle pulse on edge-box exit
//   shots        launches since reset, wraps
//   landings     ground hits since reset, saturates
module projectile_engine #(
    parameter int X_INIT      = 215,
    parameter int Y_INIT      = 465,
    parameter int GROUND_Y    = 475,
    parameter int RIGHT_WALL  = 775,
    parameter int TOP_WALL    = 50,
    parameter int GRAVITY     = 1,
    parameter int VY_MAX      = 15,
    parameter int UPDATE_LINE = 515,
    parameter int HOLD_FRAMES = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       button,
    input  logic [7:0] vel_x,
    input  logic [7:0] vel_y,
    input  logic [9:0] hCount,
    input  logic [9:0] vCount,
    output logic [9:0] projX,
    output logic [9:0] projY,
    output logic       proj_active,
    output logic       hit_ground,
    output logic       hit_wall,
    output logic [7:0] shots,
    output logic [7:0] landings
);

    localparam int unsigned AW     = 12;
    localparam int unsigned HOLD_W = $clog2(HOLD_FRAMES + 1);

    localparam logic signed [AW-1:0] XI      = AW'(X_INIT);
    localparam logic signed [AW-1:0] YI      = AW'(Y_INIT);
    localparam logic signed [AW-1:0] GND     = AW'(GROUND_Y);
    localparam logic signed [AW-1:0] GND_M1  = AW'(GROUND_Y - 1);
    localparam logic signed [AW-1:0] RW      = AW'(RIGHT_WALL);
    localparam logic signed [AW-1:0] RW_M1   = AW'(RIGHT_WALL - 1);
    localparam logic signed [AW-1:0] TW      = AW'(TOP_WALL);
    localparam logic signed [AW-1:0] GRAV    = AW'(GRAVITY);
    localparam logic signed [AW-1:0] VYMAX   = AW'(VY_MAX);
    localparam logic signed [AW-1:0] POS_MAX = AW'(1023);
    localparam logic signed [AW-1:0] POS_MIN = AW'(0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FLY,
        S_LANDED,
        S_OUT
    } state_e;

    state_e                  state_q, state_d;
    logic signed [AW-1:0]    px_q, px_d, py_q, py_d;
    logic signed [AW-1:0]    vx_q, vx_d, vy_q, vy_d;
    logic [HOLD_W-1:0]       hold_q, hold_d;
    logic                    active_q, active_d;
    logic                    hit_g_q, hit_g_d;
    logic                    hit_w_q, hit_w_d;
    logic [7:0]              shots_q, shots_d;
    logic [7:0]              land_q, land_d;
    logic                    btn_q;
    logic [9:0]              vcount_q;

    logic                    upd_c, fire_c;
    logic signed [AW-1:0]    nx_c, ny_c, vy_inc_c, nvy_c;
    logic                    unused_bits_c;

    // Keep a position inside the 10-bit display range.
    function automatic logic signed [AW-1:0] clamp10(input logic signed [AW-1:0] v);
        if (v < POS_MIN) begin
            return POS_MIN;
        end else if (v > POS_MAX) begin
            return POS_MAX;
        end
        return v;
    endfunction

    // Frame strobe on the first cycle vCount reaches the update line; launch on button rise.
    assign upd_c  = (vCount == 10'(UPDATE_LINE)) && (vcount_q != 10'(UPDATE_LINE));
    assign fire_c = button && !btn_q;

    // Candidate next position and gravity-updated vertical speed.
    assign nx_c     = px_q + vx_q;
    assign ny_c     = py_q + vy_q;
    assign vy_inc_c = vy_q + GRAV;
    assign nvy_c    = (vy_inc_c > VYMAX) ? VYMAX : vy_inc_c;

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state_q;
        px_d     = px_q;
        py_d     = py_q;
        vx_d     = vx_q;
        vy_d     = vy_q;
        hold_d   = hold_q;
        shots_d  = shots_q;
        land_d   = land_q;
        hit_g_d  = 1'b0;
        hit_w_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                px_d = XI;
                py_d = YI;
                if (fire_c) begin
                    vx_d    = $signed({4'b0000, vel_x});
                    vy_d    = -$signed({4'b0000, vel_y});
                    shots_d = shots_q + 8'd1;
                    hold_d  = '0;
                    state_d = S_FLY;
                end
            end
            S_FLY: begin
                if (upd_c) begin
                    // Ground wins over a simultaneous edge-box exit.
                    if (ny_c >= GND) begin
                        py_d    = GND_M1;
                        px_d    = (nx_c > RW_M1) ? RW_M1 : nx_c;
                        hit_g_d = 1'b1;
                        if (land_q != 8'hFF) begin
                            land_d = land_q + 8'd1;
                        end
                        state_d = S_LANDED;
                    end else if ((nx_c >= RW) || (ny_c <= TW)) begin
                        px_d    = clamp10(nx_c);
                        py_d    = clamp10(ny_c);
                        hit_w_d = 1'b1;
                        state_d = S_OUT;
                    end else begin
                        px_d = nx_c;
                        py_d = ny_c;
                        vy_d = nvy_c;
                    end
                end
            end
            S_LANDED, S_OUT: begin
                if (upd_c) begin
                    if (hold_q == HOLD_W'(HOLD_FRAMES - 1)) begin
                        hold_d  = '0;
                        px_d    = XI;
                        py_d    = YI;
                        state_d = S_IDLE;
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        active_d = (state_d == S_FLY);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            px_q     <= XI;
            py_q     <= YI;
            vx_q     <= '0;
            vy_q     <= '0;
            hold_q   <= '0;
            active_q <= 1'b0;
            hit_g_q  <= 1'b0;
            hit_w_q  <= 1'b0;
            shots_q  <= '0;
            land_q   <= '0;
            btn_q    <= 1'b0;
            vcount_q <= '0;
        end else begin
            state_q  <= state_d;
            px_q     <= px_d;
            py_q     <= py_d;
            vx_q     <= vx_d;
            vy_q     <= vy_d;
            hold_q   <= hold_d;
            active_q <= active_d;
            hit_g_q  <= hit_g_d;
            hit_w_q  <= hit_w_d;
            shots_q  <= shots_d;
            land_q   <= land_d;
            btn_q    <= button;
            vcount_q <= vCount;
        end
    end

    assign projX       = px_q[9:0];
    assign projY       = py_q[9:0];
    assign proj_active = active_q;
    assign hit_ground  = hit_g_q;
    assign hit_wall    = hit_w_q;
    assign shots       = shots_q;
    assign landings    = land_q;

    // Positions are always clamped into 10 bits; hCount is not needed by the physics.
    assign unused_bits_c = ^{hCount, px_q[AW-1:10], py_q[AW-1:10]};

endmodule

// File: doc/projectile_engine.md
Name: projectile_engine

Overview:
- Per-frame projectile physics stage that sits directly upstream of the VGA pixel painter.
- On a fire-button press it launches a projectile from the cannon mouth, with an initial velocity set by the inputs.
- Once per frame it integrates position under gravity and detects ground and edge-box collisions.
- It publishes projX/projY/proj_active, which the painter uses to draw the projectile box. Shot and landing counts feed the score display.

Parameters:
- X_INIT, 215, launch X (cannon right edge), pixels in hCount space
- Y_INIT, 465, launch Y (cannon top), pixels in vCount space
- GROUND_Y, 475, top of ground plane; landing when Y >= this
- RIGHT_WALL, 775, right edge box; out when X >= this
- TOP_WALL, 50, top edge box; out when Y <= this
- GRAVITY, 1, added to vy each frame update (px/frame^2)
- VY_MAX, 15, saturation limit for downward vy
- UPDATE_LINE, 515, vCount value that triggers the frame update (first blanking line)
- HOLD_FRAMES, 30, frames spent in LANDED/OUT before returning to IDLE

Ports:
- clk  in  1  system clock (same clock as the display counters)
- reset  in  1  asynchronous, active-low reset
- button  in  1  fire request, debounced, synchronous to clk
- vel_x  in  8  unsigned horizontal launch speed, px/frame
- vel_y  in  8  unsigned upward launch speed, px/frame
- hCount  in  10  current horizontal pixel count (unused except for lint)
- vCount  in  10  current vertical line count
- projX  out  10  projectile X, hCount space
- projY  out  10  projectile Y, vCount space
- proj_active  out  1  high while the projectile is in flight
- hit_ground  out  1  one-cycle pulse on landing
- hit_wall  out  1  one-cycle pulse on edge-box exit
- shots  out  8  launches since reset; wraps 255->0
- landings  out  8  ground hits since reset; saturates at 255

Behaviour:
- Reset (reset=0, async) forces the following:
  - state=IDLE
  - projX=X_INIT, projY=Y_INIT
  - proj_active=0, hit_ground=0, hit_wall=0
  - shots=0, landings=0
  - internal vx/vy=0, hold counter=0, button_q=0, vCount_q=0
- Frame strobe:
  - vCount_q is a registered copy of vCount.
  - upd = (vCount==UPDATE_LINE) && (vCount_q!=UPDATE_LINE). This gives exactly one clk pulse per frame.
- Button edge: fire = button && !button_q. Holding the button fires once; it must be released and pressed again to fire again.
- Internal arithmetic:
  - px, py, vx, vy are signed 12-bit.
  - vx = zero-extended vel_x; vy = -(zero-extended vel_y).
  - projX/projY are px[9:0]/py[9:0] of the clamped values.
- States:
  - IDLE:
    - proj_active=0; positions held at X_INIT/Y_INIT.
    - On fire, in the next cycle: load px=X_INIT, py=Y_INIT, vx, vy; shots+1; go to FLY; proj_active=1.
    - fire and upd in the same cycle: the launch takes priority; no integration occurs that cycle.
  - FLY:
    - On each upd compute nx=px+vx, ny=py+vy, nvy=min(vy+GRAVITY, VY_MAX).
    - Collision checks in priority order:
      - ny >= GROUND_Y: py=GROUND_Y-1, px=min(nx, RIGHT_WALL-1); hit_ground pulse; landings+1 (saturating); go to LANDED.
      - else nx >= RIGHT_WALL or ny <= TOP_WALL (signed compare; negative Y counts as out): px=nx, py=ny, each clamped into [0, 1023]; hit_wall pulse; go to OUT.
      - else px=nx, py=ny, vy=nvy; stay in FLY.
    - A simultaneous ground and wall condition resolves as ground.
    - fire is ignored in FLY.
  - LANDED / OUT:
    - proj_active=0; positions frozen.
    - Hold counter counts upd pulses; after HOLD_FRAMES pulses go to IDLE and reload projX/projY=X_INIT/Y_INIT.
    - fire is ignored in these states.
- Pulse timing: hit_ground/hit_wall are asserted for exactly the one clk cycle after the upd that detected the collision, coincident with the state change.
- Reset mid-flight: immediate return to the reset values; counters are cleared.

Test Plan:
- Basic flight:
  - Stimulus: reset; vel_x=4, vel_y=10; one button pulse; run 22 frames.
  - Required: shots=1; proj_active=1 from the cycle after the press.
  - After upd 1: projX=219, projY=455.
  - After upd 21: projY=465.
  - At upd 22: hit_ground pulses once; projX=303, projY=474; landings=1; proj_active=0.
- Right-wall exit: vel_x=40, vel_y=20, fire -> at upd 14, hit_wall pulses; projX=775, projY=276; state OUT; landings unchanged.
- Top-wall exit: vel_x=1, vel_y=40, fire -> upd 12 gives projY=51 (still FLY); upd 13 gives hit_wall, projY=23, projX=228.
- Button handling:
  - Hold button high across 5 frames -> shots=1.
  - Press during FLY -> ignored.
  - After landing plus 30 upd pulses -> back to IDLE with projX=215, projY=465; a new press gives shots=2.
- Strobe: hold vCount at 515 for 800 cycles -> exactly one integration step; step vCount 514->515->516 -> one upd.
- Reset mid-flight: assert reset at upd 10 -> immediately projX=215, projY=465, proj_active=0, shots=0, with no hit pulse.
